// File: rtl/rx_samp_sched.sv
// rtl/rx_samp_sched.sv - round-robin scheduler for the rx sample-memory write port
//
// Purpose:
//   Shares the rx audio sample-memory write port among NCHAN DDC channels.
//   Per-channel sample-available pulses are latched as pending requests and
//   one enabled channel at a time is granted, round-robin. Each grant moves
//   three words (I, Q, third word). Completed rounds are counted, and buf_done
//   pulses once nrx_samps rounds have been written.
//
// Ports:
//   adc_clk     in   1       clock, all logic on posedge
//   reset       in   1       asynchronous active-high reset
//   chan_en     in   NCHAN   channel enable mask
//   nrx_samps   in   16      rounds per buffer (0 behaves as 1)
//   avail       in   NCHAN   per-channel new-sample pulse
//   clr_overrun in   1       clears the overrun flags
//   rd_sel      out  CHAN_W  granted channel index, held while idle
//   rd_getI     out  1       pop I word from the selected channel
//   rd_getQ     out  1       pop Q word from the selected channel
//   wr          out  1       sample memory write strobe
//   busy        out  1       a move is in progress
//   buf_done    out  1       one-cycle pulse when a buffer's rounds are written
//   count       out  16      rounds completed in the current buffer
//   overrun     out  NCHAN   sticky: avail while already pending
module rx_samp_sched #(
  parameter int NCHAN  = 8,
  parameter int CHAN_W = 3
) (
  input  logic              adc_clk,
  input  logic              reset,
  input  logic [NCHAN-1:0]  chan_en,
  input  logic [15:0]       nrx_samps,
  input  logic [NCHAN-1:0]  avail,
  input  logic              clr_overrun,
  output logic [CHAN_W-1:0] rd_sel,
  output logic              rd_getI,
  output logic              rd_getQ,
  output logic              wr,
  output logic              busy,
  output logic              buf_done,
  output logic [15:0]       count,
  output logic [NCHAN-1:0]  overrun
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NCHAN-1:0]  pending_q, pending_d;
  logic [NCHAN-1:0]  served_q, served_d;
  logic [NCHAN-1:0]  overrun_q, overrun_d;
  logic [CHAN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHAN_W-1:0] sel_q, sel_d;
  logic [15:0]       count_q, count_d;
  logic              buf_done_q, buf_done_d;
  logic              get_i_q, get_i_d;
  logic              get_q_q, get_q_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;

  logic [NCHAN-1:0]  req;
  logic [NCHAN-1:0]  grant_mask;
  logic [NCHAN-1:0]  served_sel;
  logic [CHAN_W:0]   scan_idx;
  logic [CHAN_W-1:0] pick;
  logic              pick_vld;
  logic              grant;
  logic              round_done;
  logic [16:0]       count_inc;
  logic [16:0]       limit;

  assign req = pending_q & chan_en;

  // Round-robin pick: first requester at or above rr_ptr, wrapping at NCHAN.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NCHAN; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CHAN_W+1)'(k);
      if (scan_idx >= (CHAN_W+1)'(NCHAN)) begin
        scan_idx = scan_idx - (CHAN_W+1)'(NCHAN);
      end
      if (!pick_vld && req[scan_idx[CHAN_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = scan_idx[CHAN_W-1:0];
      end
    end
  end

  assign grant      = (state_q == S_IDLE) && pick_vld;
  assign grant_mask = grant ? (NCHAN'(1) << pick) : '0;
  assign served_sel = served_q | (NCHAN'(1) << sel_q);
  // A channel whose enable dropped must not hold the round open, so only
  // enabled bits are compared.
  assign round_done = (served_sel & chan_en) == chan_en;
  assign count_inc  = {1'b0, count_q} + 17'd1;
  assign limit      = (nrx_samps == 16'd0) ? 17'd1 : {1'b0, nrx_samps};

  // FSM: state register
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_W0;
      S_W0:    state_d = S_W1;
      S_W1:    state_d = S_W2;
      S_W2:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the next state so the registered strobes
  // line up with the state they belong to.
  always_comb begin
    get_i_d = (state_d == S_W0);
    get_q_d = (state_d == S_W1);
    wr_d    = (state_d == S_W0) || (state_d == S_W1) || (state_d == S_W2);
    busy_d  = (state_d != S_IDLE);
  end

  // Request, round and buffer bookkeeping.
  always_comb begin
    // New avail wins over the grant clear of the same cycle.
    pending_d  = (pending_q & ~grant_mask) | avail;
    overrun_d  = clr_overrun ? '0 : (overrun_q | (avail & pending_q & ~grant_mask));
    sel_d      = grant ? pick : sel_q;
    served_d   = served_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    buf_done_d = 1'b0;
    if (state_q == S_DONE) begin
      rr_ptr_d = (sel_q == CHAN_W'(NCHAN-1)) ? '0 : sel_q + CHAN_W'(1);
      if (round_done) begin
        served_d = '0;
        if (count_inc >= limit) begin
          buf_done_d = 1'b1;
          count_d    = '0;
        end else begin
          count_d = count_inc[15:0];
        end
      end else begin
        served_d = served_sel;
      end
    end
    served_d = served_d & chan_en;
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      served_q   <= '0;
      overrun_q  <= '0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      count_q    <= '0;
      buf_done_q <= 1'b0;
      get_i_q    <= 1'b0;
      get_q_q    <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      served_q   <= served_d;
      overrun_q  <= overrun_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      buf_done_q <= buf_done_d;
      get_i_q    <= get_i_d;
      get_q_q    <= get_q_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_sel   = sel_q;
  assign rd_getI  = get_i_q;
  assign rd_getQ  = get_q_q;
  assign wr       = wr_q;
  assign busy     = busy_q;
  assign buf_done = buf_done_q;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_samp_sched.sv
// tb/tb_rx_samp_sched.sv - directed self-checking bench for rx_samp_sched
module tb_rx_samp_sched;

  localparam int NCHAN  = 8;
  localparam int CHAN_W = 3;

  logic              adc_clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCHAN-1:0]  chan_en = '0;
  logic [15:0]       nrx_samps = '0;
  logic [NCHAN-1:0]  avail = '0;
  logic              clr_overrun = 1'b0;
  logic [CHAN_W-1:0] rd_sel;
  logic              rd_getI, rd_getQ, wr, busy, buf_done;
  logic [15:0]       count;
  logic [NCHAN-1:0]  overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nbuf = 0;
  logic [1:0]        wr_log[$];
  logic [CHAN_W-1:0] grant_log[$];
  int                grant_cyc[$];

  rx_samp_sched #(.NCHAN(NCHAN), .CHAN_W(CHAN_W)) dut (
    .adc_clk(adc_clk), .reset(reset), .chan_en(chan_en), .nrx_samps(nrx_samps),
    .avail(avail), .clr_overrun(clr_overrun), .rd_sel(rd_sel), .rd_getI(rd_getI),
    .rd_getQ(rd_getQ), .wr(wr), .busy(busy), .buf_done(buf_done), .count(count),
    .overrun(overrun)
  );

  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) cyc <= cyc + 1;

  // Mid-cycle observer of the write bursts, grants and buffer pulses.
  always @(negedge adc_clk) begin
    if (!reset) begin
      if (wr) wr_log.push_back({rd_getI, rd_getQ});
      if (rd_getI) begin
        grant_log.push_back(rd_sel);
        grant_cyc.push_back(cyc);
      end
      if (buf_done) nbuf = nbuf + 1;
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    grant_log.delete();
    grant_cyc.delete();
    nbuf = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    avail = '0;
    clr_overrun = 1'b0;
    chan_en = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_avail(input logic [NCHAN-1:0] m);
    avail = m;
    tick();
    avail = '0;
  endtask

  task automatic wait_moves(input int n, output bit ok);
    int t = 0;
    while ((grant_log.size() < n || busy) && t < 80) begin
      tick();
      t++;
    end
    tick();
    ok = (t < 80);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rd_sel, rd_getI, rd_getQ, wr, busy, buf_done} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 00000000", {rd_sel, rd_getI, rd_getQ, wr, busy, buf_done});
    end
    n_cmp++;
    if (count !== 16'd0 || overrun !== 8'h00) begin
      n_err++;
      $display("FAIL reset_cnt: count=%0d overrun=%h want 0/00", count, overrun);
    end
    do_reset();
  endtask

  task automatic test_single_channel();
    bit ok;
    logic [1:0] exp_p[3];
    exp_p[0] = 2'b10;
    exp_p[1] = 2'b01;
    exp_p[2] = 2'b00;
    do_reset();
    chan_en = 8'h01;
    nrx_samps = 16'd2;
    pulse_avail(8'h01);
    wait_moves(1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t1_timeout1: move did not finish"); end
    n_cmp++;
    if (count !== 16'd1 || nbuf !== 0) begin
      n_err++;
      $display("FAIL t1_first: count=%0d bufs=%0d want 1/0", count, nbuf);
    end
    pulse_avail(8'h01);
    wait_moves(2, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t1_timeout2: move did not finish"); end
    n_cmp++;
    if (count !== 16'd0 || nbuf !== 1) begin
      n_err++;
      $display("FAIL t1_bufdone: count=%0d bufs=%0d want 0/1", count, nbuf);
    end
    n_cmp++;
    if (wr_log.size() !== 6) begin
      n_err++;
      $display("FAIL t1_wrlen: wr cycles=%0d want 6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (wr_log[i] !== exp_p[i % 3]) begin
          n_err++;
          $display("FAIL t1_burst[%0d]: getI/getQ=%b want %b", i, wr_log[i], exp_p[i % 3]);
        end
      end
    end
  endtask

  task automatic test_four_channels();
    bit ok;
    do_reset();
    chan_en = 8'h0F;
    nrx_samps = 16'd4;
    pulse_avail(8'h0F);
    wait_moves(4, ok);
    n_cmp++;
    if (!ok || grant_log.size() !== 4) begin
      n_err++;
      $display("FAIL t2_grants: got %0d grants want 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (grant_log[i] !== CHAN_W'(i)) begin
          n_err++;
          $display("FAIL t2_order[%0d]: got ch%0d want ch%0d", i, grant_log[i], i);
        end
        if (i > 0) begin
          n_cmp++;
          if (grant_cyc[i] - grant_cyc[i-1] !== 5) begin
            n_err++;
            $display("FAIL t2_spacing[%0d]: got %0d cycles want 5", i, grant_cyc[i] - grant_cyc[i-1]);
          end
        end
      end
    end
    n_cmp++;
    if (count !== 16'd1 || nbuf !== 0) begin
      n_err++;
      $display("FAIL t2_count: count=%0d bufs=%0d want 1/0", count, nbuf);
    end
  endtask

  task automatic test_rr_fairness();
    bit ok;
    do_reset();
    chan_en = 8'h0F;
    nrx_samps = 16'd4;
    pulse_avail(8'h02);
    tick();
    tick();
    pulse_avail(8'h05);
    wait_moves(3, ok);
    n_cmp++;
    if (!ok || grant_log.size() !== 3) begin
      n_err++;
      $display("FAIL t3_grants: got %0d grants want 3", grant_log.size());
    end else begin
      n_cmp++;
      if ({grant_log[0], grant_log[1], grant_log[2]} !== {3'd1, 3'd2, 3'd0}) begin
        n_err++;
        $display("FAIL t3_order: got %0d,%0d,%0d want 1,2,0", grant_log[0], grant_log[1], grant_log[2]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    nrx_samps = 16'd4;
    pulse_avail(8'h02);
    pulse_avail(8'h02);
    tick();
    n_cmp++;
    if (overrun !== 8'h02) begin
      n_err++;
      $display("FAIL t4_set: overrun=%h want 02", overrun);
    end
    n_cmp++;
    if (grant_log.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t4_noen: grants=%0d busy=%b want 0/0", grant_log.size(), busy);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    n_cmp++;
    if (overrun !== 8'h00) begin
      n_err++;
      $display("FAIL t4_clr: overrun=%h want 00", overrun);
    end
    avail = 8'h02;
    clr_overrun = 1'b1;
    tick();
    avail = '0;
    clr_overrun = 1'b0;
    n_cmp++;
    if (overrun !== 8'h00) begin
      n_err++;
      $display("FAIL t4_clrprio: overrun=%h want 00", overrun);
    end
    chan_en = 8'h02;
    tick();
    pulse_avail(8'h02);
    wait_moves(2, ok);
    n_cmp++;
    if (overrun !== 8'h00) begin
      n_err++;
      $display("FAIL t4_inmove: overrun=%h want 00", overrun);
    end
    n_cmp++;
    if (!ok || grant_log.size() !== 2 || grant_log[0] !== 3'd1 || grant_log[1] !== 3'd1) begin
      n_err++;
      $display("FAIL t4_regrant: grants=%0d want 2 of ch1", grant_log.size());
    end
  endtask

  task automatic test_nrx_zero_and_mask();
    bit ok;
    do_reset();
    chan_en = 8'h01;
    nrx_samps = 16'd0;
    pulse_avail(8'h01);
    wait_moves(1, ok);
    n_cmp++;
    if (!ok || nbuf !== 1 || count !== 16'd0) begin
      n_err++;
      $display("FAIL t5_zero1: bufs=%0d count=%0d want 1/0", nbuf, count);
    end
    pulse_avail(8'h01);
    wait_moves(2, ok);
    n_cmp++;
    if (!ok || nbuf !== 2 || count !== 16'd0) begin
      n_err++;
      $display("FAIL t5_zero2: bufs=%0d count=%0d want 2/0", nbuf, count);
    end
    chan_en = 8'h03;
    nrx_samps = 16'd5;
    pulse_avail(8'h01);
    wait_moves(3, ok);
    n_cmp++;
    if (!ok || count !== 16'd0) begin
      n_err++;
      $display("FAIL t5_partial: count=%0d want 0", count);
    end
    chan_en = 8'h01;
    pulse_avail(8'h01);
    wait_moves(4, ok);
    n_cmp++;
    if (!ok || count !== 16'd1 || nbuf !== 2) begin
      n_err++;
      $display("FAIL t5_mask: count=%0d bufs=%0d want 1/2", count, nbuf);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int t = 0;
    do_reset();
    chan_en = 8'h01;
    nrx_samps = 16'd4;
    pulse_avail(8'h01);
    wait_moves(1, ok);
    n_cmp++;
    if (!ok || count !== 16'd1) begin
      n_err++;
      $display("FAIL t6_pre: count=%0d want 1", count);
    end
    pulse_avail(8'h01);
    while (!rd_getQ && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (rd_getQ !== 1'b1 || wr !== 1'b1) begin
      n_err++;
      $display("FAIL t6_w1: getQ=%b wr=%b want 1/1", rd_getQ, wr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wr, rd_getQ, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL t6_async: wr/getQ/busy=%b want 000", {wr, rd_getQ, busy});
    end
    tick();
    reset = 1'b0;
    clear_logs();
    chan_en = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (count !== 16'd0 || grant_log.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t6_after: count=%0d grants=%0d busy=%b want 0/0/0", count, grant_log.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_four_channels();
    test_rr_fairness();
    test_overrun();
    test_nrx_zero_and_mask();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
